// File: rtl/cntr_param.sv
// Parametrised up/down counter with wrap, saturate and one-shot run modes.
// Synchronous clear and load; registered count, terminal-count pulse and done flag.
module cntr_param #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_sig,
    input  logic             up_sig,
    input  logic             clr_sig,
    input  logic             load_sig,
    input  logic [WIDTH-1:0] load_val_sig,
    input  logic [1:0]       mode_sig,
    output logic [WIDTH-1:0] cnt_out_sig,
    output logic             tc_sig,
    output logic             done_sig
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_WRAP    = 2'd0;
    localparam logic [1:0]       MODE_SAT     = 2'd1;
    localparam logic [1:0]       MODE_ONESHOT = 2'd2;
    localparam logic [WIDTH-1:0] ZERO         = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic             tc_r;
    logic             done_r;
    logic [1:0]       mode_r;

    logic [WIDTH-1:0] load_clip_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] wrap_s;
    logic             at_term_s;
    logic             step_term_s;
    logic             mode_chg_s;
    logic             oneshot_s;
    logic             sat_s;

    // Datapath helpers: clipped load value, next step value and terminal detection
    always_comb begin
        load_clip_s = load_val_sig;
        step_s      = cnt_r;
        wrap_s      = ZERO;
        at_term_s   = 1'b0;
        step_term_s = 1'b0;
        if (load_val_sig > MAX_VAL) begin
            load_clip_s = MAX_VAL;
        end else begin
            load_clip_s = load_val_sig;
        end
        if (up_sig) begin
            step_s      = cnt_r + ONE;
            wrap_s      = ZERO;
            at_term_s   = (cnt_r == MAX_VAL);
            step_term_s = ((cnt_r + ONE) == MAX_VAL);
        end else begin
            step_s      = cnt_r - ONE;
            wrap_s      = MAX_VAL;
            at_term_s   = (cnt_r == ZERO);
            step_term_s = ((cnt_r - ONE) == ZERO);
        end
        mode_chg_s = (mode_sig != mode_r);
        oneshot_s  = (mode_sig == MODE_ONESHOT);
        sat_s      = (mode_sig == MODE_SAT);
    end

    // Control FSM and registered outputs; priority clr > load > mode change > step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= RST_VAL;
            tc_r    <= 1'b0;
            done_r  <= 1'b0;
            mode_r  <= MODE_WRAP;
        end else begin
            mode_r <= mode_sig;
            tc_r   <= 1'b0;
            if (clr_sig) begin
                cnt_r   <= ZERO;
                state_r <= ST_IDLE;
                done_r  <= 1'b0;
            end else if (load_sig) begin
                cnt_r   <= load_clip_s;
                state_r <= ST_IDLE;
                done_r  <= 1'b0;
            end else if (mode_chg_s) begin
                state_r <= ST_IDLE;
                done_r  <= 1'b0;
            end else if (oneshot_s) begin
                case (state_r)
                    ST_IDLE, ST_RUN: begin
                        if (en_sig) begin
                            // Already at the terminal: stop without stepping or pulsing
                            if (at_term_s) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end else begin
                                cnt_r <= step_s;
                                if (step_term_s) begin
                                    state_r <= ST_DONE;
                                    done_r  <= 1'b1;
                                    tc_r    <= 1'b1;
                                end else begin
                                    state_r <= ST_RUN;
                                end
                            end
                        end else begin
                            state_r <= state_r;
                        end
                    end
                    ST_DONE: begin
                        done_r <= 1'b1;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= ST_IDLE;
                done_r  <= 1'b0;
                if (en_sig) begin
                    if (at_term_s) begin
                        tc_r <= 1'b1;
                        if (!sat_s) begin
                            cnt_r <= wrap_s;
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end else begin
                        cnt_r <= step_s;
                    end
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end
    end

    assign cnt_out_sig = cnt_r;
    assign tc_sig      = tc_r;
    assign done_sig    = done_r;

endmodule

// File: tb/tb_cntr_param.sv
// Scoreboard bench for cntr_param (WIDTH=4, MAX_VAL=9, RST_VAL=0) with directed vectors.
module tb_cntr_param;

    logic       clk;
    logic       rst;
    logic       en_sig;
    logic       up_sig;
    logic       clr_sig;
    logic       load_sig;
    logic [3:0] load_val_sig;
    logic [1:0] mode_sig;
    logic [3:0] cnt_out_sig;
    logic       tc_sig;
    logic       done_sig;

    typedef struct {
        logic [5:0] val;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;
    event sample_ev;

    cntr_param #(
        .WIDTH  (4),
        .MAX_VAL(4'd9),
        .RST_VAL(4'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_sig      (en_sig),
        .up_sig      (up_sig),
        .clr_sig     (clr_sig),
        .load_sig    (load_sig),
        .load_val_sig(load_val_sig),
        .mode_sig    (mode_sig),
        .cnt_out_sig (cnt_out_sig),
        .tc_sig      (tc_sig),
        .done_sig    (done_sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drain the scoreboard on each falling edge or explicit sample request
    initial begin
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(negedge clk or sample_ev);
            while (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                got = {cnt_out_sig, tc_sig, done_sig};
                checks++;
                if (got !== e.val) begin
                    failures++;
                    $display("FAIL %s: got cnt=%0d tc=%0b done=%0b, expected cnt=%0d tc=%0b done=%0b",
                             e.name, got[5:2], got[1], got[0], e.val[5:2], e.val[1], e.val[0]);
                end
            end
        end
    end

    task automatic push(input string name, input logic [3:0] c, input logic t, input logic d);
        exp_t e;
        e.val  = {c, t, d};
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic cyc(input string name, input logic clr, input logic ld, input logic [3:0] lv,
                       input logic en, input logic up, input logic [1:0] md,
                       input logic [3:0] ec, input logic et, input logic ed);
        @(negedge clk);
        clr_sig      = clr;
        load_sig     = ld;
        load_val_sig = lv;
        en_sig       = en;
        up_sig       = up;
        mode_sig     = md;
        @(posedge clk);
        #1;
        push(name, ec, et, ed);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        en_sig       = 1'b0;
        up_sig       = 1'b1;
        clr_sig      = 1'b0;
        load_sig     = 1'b0;
        load_val_sig = 4'd0;
        mode_sig     = 2'd0;
        #1;
        push("reset_state", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // WRAP up
        cyc("wrap_load8",  1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 2'd0, 4'd8, 1'b0, 1'b0);
        cyc("wrap_step9",  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 4'd9, 1'b0, 1'b0);
        cyc("wrap_to0",    1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 4'd0, 1'b1, 1'b0);
        cyc("wrap_step1",  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0);
        // SAT down
        cyc("sat_load1",   1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd1, 4'd1, 1'b0, 1'b0);
        cyc("sat_dn0",     1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 4'd0, 1'b0, 1'b0);
        cyc("sat_hold0a",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 4'd0, 1'b1, 1'b0);
        cyc("sat_hold0b",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd1, 4'd0, 1'b1, 1'b0);
        // SAT up at MAX_VAL
        cyc("sat_load9",   1'b0, 1'b1, 4'd9, 1'b0, 1'b1, 2'd1, 4'd9, 1'b0, 1'b0);
        cyc("sat_hold9",   1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd1, 4'd9, 1'b1, 1'b0);
        cyc("sat_idle9",   1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd1, 4'd9, 1'b0, 1'b0);
        // Load clip and clr priority
        cyc("load_clip",   1'b0, 1'b1, 4'd12, 1'b0, 1'b1, 2'd0, 4'd9, 1'b0, 1'b0);
        cyc("clr_prio",    1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 2'd0, 4'd0, 1'b0, 1'b0);
        // ONESHOT up
        cyc("os_load7",    1'b0, 1'b1, 4'd7, 1'b0, 1'b1, 2'd2, 4'd7, 1'b0, 1'b0);
        cyc("os_step8",    1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 4'd8, 1'b0, 1'b0);
        cyc("os_done9",    1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 4'd9, 1'b1, 1'b1);
        cyc("os_frozen_a", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 4'd9, 1'b0, 1'b1);
        cyc("os_frozen_b", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 4'd9, 1'b0, 1'b1);
        cyc("os_load3",    1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 2'd2, 4'd3, 1'b0, 1'b0);
        cyc("os_idle_hold",1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd2, 4'd3, 1'b0, 1'b0);
        cyc("os_run4",     1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 4'd4, 1'b0, 1'b0);
        // ONESHOT down, then starting at the terminal
        cyc("os_load2",    1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 2'd2, 4'd2, 1'b0, 1'b0);
        cyc("os_dn1",      1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 4'd1, 1'b0, 1'b0);
        cyc("os_dn0_done", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 4'd0, 1'b1, 1'b1);
        cyc("os_clr",      1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2, 4'd0, 1'b0, 1'b0);
        cyc("os_at_term",  1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0, 1'b1);
        // Async reset mid-run in WRAP
        cyc("rst_load4",   1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 2'd0, 4'd4, 1'b0, 1'b0);
        cyc("rst_step5",   1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        en_sig = 1'b0;
        rst    = 1'b0;
        #1;
        push("async_rst", 4'd0, 1'b0, 1'b0);
        -> sample_ev;
        @(posedge clk);
        #1;
        push("rst_held", 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc("rst_resume",  1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 4'd1, 1'b0, 1'b0);
        // Mode switch out of DONE
        cyc("ms_load8",    1'b0, 1'b1, 4'd8, 1'b0, 1'b1, 2'd2, 4'd8, 1'b0, 1'b0);
        cyc("ms_done9",    1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd2, 4'd9, 1'b1, 1'b1);
        cyc("ms_switch",   1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 4'd9, 1'b0, 1'b0);
        cyc("ms_wrap0",    1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 2'd0, 4'd0, 1'b1, 1'b0);
        // Reserved mode behaves as WRAP, down direction
        cyc("m3_load0",    1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0, 1'b0);
        cyc("m3_wrap9",    1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 4'd9, 1'b1, 1'b0);
        cyc("m3_dn8",      1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd3, 4'd8, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
